script_sequencer: RTL

Script execution front end: owns the program counter, fetches 16-bit script words from the synchronous script ROM, and resolves control flow locally (jumps, timed waits, condition waits, halt). Action (op 001) and Game State (op 100) words are forwarded one at a time to the downstream script analyser over a valid/ready handshake, together with their `pc`. The block sits between the script memory and the analyser, and idles whenever `script_mode` is 1 (script loading).

---
 rtl/script_pkg.sv | 56 +++++
 rtl/script_sequencer_if.sv | 12 +
 rtl/script_sequencer_wait_timer.sv | 52 +++++
 rtl/script_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/script_pkg.sv
// Shared script word format, opcodes and sequencer state codes.
// Field-extract helpers are also used by the downstream script analyser.
package script_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] OP_ACTION = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_WAIT   = 3'b011;
  localparam logic [2:0] OP_STATE  = 3'b100;

  localparam logic [1:0] FUN_00 = 2'b00;
  localparam logic [1:0] FUN_01 = 2'b01;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISSUE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_TIME = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_COND = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd6;

  typedef struct packed {
    logic [7:0] i_num;
    logic [2:0] i_sign;
    logic [1:0] fun;
    logic [2:0] op;
  } script_word_t;

  function automatic logic [7:0] f_i_num(input logic [WORD_W-1:0] w);
    script_word_t s;
    s = script_word_t'(w);
    return s.i_num;
  endfunction

  function automatic logic [2:0] f_i_sign(input logic [WORD_W-1:0] w);
    script_word_t s;
    s = script_word_t'(w);
    return s.i_sign;
  endfunction

  function automatic logic [1:0] f_fun(input logic [WORD_W-1:0] w);
    script_word_t s;
    s = script_word_t'(w);
    return s.fun;
  endfunction

  function automatic logic [2:0] f_op(input logic [WORD_W-1:0] w);
    script_word_t s;
    s = script_word_t'(w);
    return s.op;
  endfunction

endpackage

// File: rtl/script_sequencer_if.sv
// Issue channel from the sequencer to the script analyser; pc doubles as ROM address.
interface script_sequencer_if;
  import script_pkg::*;

  logic [PC_W-1:0]   pc;
  logic [WORD_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;

  modport master (output pc, output instr, output instr_valid, input instr_ready);
  modport slave  (input pc, input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/script_sequencer_wait_timer.sv
// Timed-wait engine: tick prescaler feeding an 8-bit tick down-counter.
// expire_c_o flags the final cycle of a loaded i_num x TICK_CYCLES interval.
module wait_timer #(
  parameter int unsigned TICK_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       abort_i,
  input  logic       en_i,
  input  logic [7:0] ticks_i,
  output logic       expire_c_o
);
  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    ticks_q, ticks_d;
  logic          tick_end_c;

  assign tick_end_c = (presc_q == PRESC_LAST);
  assign expire_c_o = en_i && tick_end_c && (ticks_q == 8'd1);

  always_comb begin
    presc_d = presc_q;
    ticks_d = ticks_q;
    if (abort_i) begin
      presc_d = '0;
      ticks_d = '0;
    end else if (load_i) begin
      presc_d = '0;
      ticks_d = ticks_i;
    end else if (en_i && (ticks_q != 8'd0)) begin
      if (tick_end_c) begin
        presc_d = '0;
        ticks_d = ticks_q - 8'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      ticks_q <= '0;
    end else begin
      presc_q <= presc_d;
      ticks_q <= ticks_d;
    end
  end
endmodule

// File: rtl/script_sequencer.sv
// Script execution front end: owns the pc, fetches ROM words, resolves jumps and
// waits locally, and forwards action/state words to the analyser.
module script_sequencer
  import script_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                script_mode,
  input  logic                start,
  input  logic [WORD_W-1:0]   script_data,
  input  logic [7:0]          feedback,
  script_sequencer_if.master  bus,
  output logic                busy,
  output logic                done
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [WORD_W-1:0]  instr_q, instr_d;
  logic [2:0]         sel_q, sel_d;
  logic               valid_q, busy_q, done_q;
  logic               tmr_load, tmr_abort, tmr_expire;

  assign pc_inc = pc_q + PC_W'(1);

  wait_timer #(.TICK_CYCLES(TICK_CYCLES)) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .abort_i    (tmr_abort),
    .en_i       (state_q == ST_WAIT_TIME),
    .ticks_i    (f_i_num(script_data)),
    .expire_c_o (tmr_expire)
  );

  // Next-state logic; script_mode overrides every other transition.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    sel_d     = sel_q;
    tmr_load  = 1'b0;
    tmr_abort = 1'b0;
    if (script_mode) begin
      state_d   = ST_IDLE;
      pc_d      = '0;
      tmr_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pc_d = '0;
          if (start) state_d = ST_FETCH;
        end
        ST_FETCH: state_d = ST_DECODE;
        ST_DECODE: begin
          // Unrecognised words fall through as a skip.
          state_d = ST_FETCH;
          pc_d    = pc_inc;
          if (script_data == '0) begin
            state_d = ST_DONE;
            pc_d    = pc_q;
          end else begin
            case (f_op(script_data))
              OP_ACTION, OP_STATE: begin
                instr_d = script_data;
                state_d = ST_ISSUE;
                pc_d    = pc_q;
              end
              OP_JUMP: begin
                if ((f_fun(script_data) == FUN_00 || f_fun(script_data) == FUN_01) &&
                    (feedback[f_i_sign(script_data)] ^ (f_fun(script_data) == FUN_01)))
                  pc_d = f_i_num(script_data);
              end
              OP_WAIT: begin
                if (f_fun(script_data) == FUN_00 && f_i_num(script_data) != 8'd0) begin
                  tmr_load = 1'b1;
                  state_d  = ST_WAIT_TIME;
                  pc_d     = pc_q;
                end else if (f_fun(script_data) == FUN_01) begin
                  sel_d   = f_i_sign(script_data);
                  state_d = ST_WAIT_COND;
                  pc_d    = pc_q;
                end
              end
              default: ;
            endcase
          end
        end
        ST_ISSUE: begin
          if (bus.instr_ready) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        end
        ST_WAIT_TIME: begin
          if (tmr_expire) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        end
        ST_WAIT_COND: begin
          if (feedback[sel_q]) begin
            pc_d    = pc_inc;
            state_d = ST_FETCH;
          end
        end
        ST_DONE: begin
          if (start) begin
            pc_d    = '0;
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      sel_q   <= sel_d;
      valid_q <= (state_d == ST_ISSUE);
      busy_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
endmodule
